debug_uart: RTL and testbench

DEBUG_UART -- requirements
Module: debug_uart

---
 rtl/debug_uart_pkg.sv | 18 +
 rtl/debug_uart_tx.sv | 83 ++++++++
 rtl/debug_uart.sv | 101 ++++++++++
 tb/tb_debug_uart.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared constants and helpers for the debug UART telemetry streamer.
package debug_uart_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_e;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/debug_uart_tx.sv
// 8N1 byte serializer; accepts the next byte in the same cycle its stop bit ends,
// so a continuously valid source produces a gapless stream.
module uart_tx
  import debug_uart_pkg::*;
#(
  parameter int DIV = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  tx_state_e      state_q, state_d;
  logic [8:0]     shift_q;
  logic [3:0]     bit_q;
  logic [DW-1:0]  div_q;
  logic           bit_end;
  logic           load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    load    = 1'b0;
    bit_end = (div_q == DIV_LAST);
    case (state_q)
      TX_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          load    = 1'b1;
          state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bit_end && bit_q == 4'd9) begin
          ready = 1'b1;
          if (valid) load = 1'b1;
          else       state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // bit_q: 0 = start, 1..8 = data, 9 = stop; shift_q[0] is always the next bit out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      shift_q <= '1;
      bit_q   <= '0;
      div_q   <= '0;
    end else if (load) begin
      tx      <= 1'b0;
      shift_q <= {1'b1, data};
      bit_q   <= '0;
      div_q   <= '0;
    end else if (state_q == TX_BUSY) begin
      if (bit_end) begin
        div_q <= '0;
        if (bit_q == 4'd9) begin
          tx <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx      <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_uart.sv
// Streams "MMDDSSSSSSSS JJ A0 A1 A2 A3\r\n" telemetry frames back-to-back over an 8N1 UART.
module debug_uart
  import debug_uart_pkg::*;
#(
  parameter int W   = 16,
  parameter int DIV = 12
) (
  input  logic         clk,
  input  logic         rst,
  output logic         tx_o,
  input  logic [W-1:0] adc0,
  input  logic [W-1:0] adc1,
  input  logic [W-1:0] adc2,
  input  logic [W-1:0] adc3,
  input  logic [7:0]   eeprom_mfg,
  input  logic [7:0]   eeprom_dev,
  input  logic [31:0]  eeprom_serial,
  input  logic [7:0]   jack
);

  localparam int N         = (W + 3) / 4;
  localparam int AW        = 4 * N;
  localparam int FRAME_LEN = 21 + 4 * N;
  localparam int BW        = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);

  logic [7:0]    mfg_q, dev_q, jack_q;
  logic [31:0]   serial_q;
  logic [AW-1:0] adc_q [4];
  logic [BW-1:0] idx_q;
  logic [7:0]    mfg_src;
  logic [AW-1:0] adc_sel;
  logic [7:0]    tx_char;
  logic [3:0]    nib;
  logic          is_hex;
  logic          ready;

  // Byte 0 goes out in the snapshot cycle itself, so it must read the live input.
  assign mfg_src = (idx_q == '0) ? eeprom_mfg : mfg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      mfg_q    <= '0;
      dev_q    <= '0;
      serial_q <= '0;
      jack_q   <= '0;
      for (int n = 0; n < 4; n++) adc_q[n] <= '0;
    end else if (ready) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + BW'(1);
      if (idx_q == '0) begin
        mfg_q    <= eeprom_mfg;
        dev_q    <= eeprom_dev;
        serial_q <= eeprom_serial;
        jack_q   <= jack;
        adc_q[0] <= AW'($signed(adc0));
        adc_q[1] <= AW'($signed(adc1));
        adc_q[2] <= AW'($signed(adc2));
        adc_q[3] <= AW'($signed(adc3));
      end
    end
  end

  always_comb begin
    int i, j, k, d;
    i       = int'(idx_q);
    j       = i - 15;
    k       = j / (N + 1);
    d       = j % (N + 1);
    adc_sel = adc_q[k[1:0]];
    nib     = '0;
    is_hex  = 1'b1;
    tx_char = ASCII_SPACE;
    if (i < 2)       nib = 4'(mfg_src >> (4 * (1 - i)));
    else if (i < 4)  nib = 4'(dev_q >> (4 * (3 - i)));
    else if (i < 12) nib = 4'(serial_q >> (4 * (11 - i)));
    else if (i < 15) begin
      is_hex = (i != 12);
      nib    = 4'(jack_q >> (4 * (14 - i)));
    end else if (i >= FRAME_LEN - 2) begin
      is_hex = 1'b0;
    end else begin
      // Each ADC field is a leading space followed by N digits, MSB nibble first.
      is_hex = (d != 0);
      nib    = 4'(adc_sel >> (4 * (N - d)));
    end
    if (is_hex)                   tx_char = hex_ascii(nib);
    else if (i == FRAME_LEN - 2)  tx_char = ASCII_CR;
    else if (i == FRAME_LEN - 1)  tx_char = ASCII_LF;
  end

  uart_tx #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (1'b1),
    .data  (tx_char),
    .ready (ready),
    .tx    (tx_o)
  );

endmodule

// File: tb/tb_debug_uart.sv
// Bench for debug_uart: three configurations decoded by background UART receivers,
// checked against hand-written frame text and cycle timing.
module tb_debug_uart;

  typedef struct {
    logic [7:0]  mfg;
    logic [7:0]  dev;
    logic [31:0] serial;
    logic [7:0]  jack;
    logic [15:0] a0, a1, a2, a3;
    string       text;
  } vec_t;

  typedef struct {
    string text;
    int    start;
    int    gaps;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  string crlf;

  logic [15:0] adc0, adc1, adc2, adc3;
  logic [7:0]  mfg, dev, jack;
  logic [31:0] serial;
  logic [11:0] b0 = 12'hFFF, b1 = 12'h800, b2 = 12'h07F, b3 = 12'h000;
  logic [15:0] z16 = '0;
  logic [7:0]  z8 = '0;
  logic [31:0] z32 = '0;
  logic tx_main, tx_w12, tx_div2;

  frame_t q_main[$], q_w12[$], q_div2[$];
  vec_t   vecs[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_uart #(.W(16), .DIV(12)) dut (
    .clk(clk), .rst(rst), .tx_o(tx_main),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
    .eeprom_mfg(mfg), .eeprom_dev(dev), .eeprom_serial(serial), .jack(jack));

  debug_uart #(.W(12), .DIV(4)) dut_w12 (
    .clk(clk), .rst(rst), .tx_o(tx_w12),
    .adc0(b0), .adc1(b1), .adc2(b2), .adc3(b3),
    .eeprom_mfg(8'hAB), .eeprom_dev(8'hC0), .eeprom_serial(32'h12345678), .jack(8'h5A));

  debug_uart #(.W(16), .DIV(2)) dut_div2 (
    .clk(clk), .rst(rst), .tx_o(tx_div2),
    .adc0(z16), .adc1(z16), .adc2(z16), .adc3(z16),
    .eeprom_mfg(z8), .eeprom_dev(z8), .eeprom_serial(z32), .jack(z8));

  function automatic logic tx_of(input int inst);
    case (inst)
      0:       return tx_main;
      1:       return tx_w12;
      default: return tx_div2;
    endcase
  endfunction

  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  // Mid-bit sampling receiver; records each byte's start cycle to catch idle gaps.
  task automatic rx_monitor(input int inst, input int div);
    string txt = "";
    int st, fstart = 0, gaps = 0, prev = -1, wait_n;
    logic [7:0] b;
    bit abort;
    frame_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        txt = ""; prev = -1; gaps = 0;
      end else if (tx_of(inst) == 1'b0) begin
        st = cyc;
        if (prev >= 0 && st - prev != 10 * div) gaps++;
        if (txt.len() == 0) fstart = st;
        prev = st; abort = 0; b = '0;
        for (int j = 0; j < 9 && !abort; j++) begin
          wait_n = (j == 0) ? div + div / 2 : div;
          for (int t = 0; t < wait_n && !abort; t++) begin
            @(negedge clk);
            if (rst) abort = 1;
          end
          if (!abort) begin
            if (j < 8) b[j] = tx_of(inst);
            else if (tx_of(inst) !== 1'b1) gaps++;
          end
        end
        if (abort) begin
          txt = ""; prev = -1; gaps = 0;
        end else begin
          txt = $sformatf("%s%c", txt, b);
          if (b == 8'h0A || txt.len() >= 80) begin
            f.text = txt; f.start = fstart; f.gaps = gaps;
            case (inst)
              0:       q_main.push_back(f);
              1:       q_w12.push_back(f);
              default: q_div2.push_back(f);
            endcase
            txt = ""; gaps = 0;
          end
        end
      end
    end
  endtask

  initial rx_monitor(0, 12);
  initial rx_monitor(1, 4);
  initial rx_monitor(2, 2);

  task automatic applyStimulus(input vec_t v);
    mfg = v.mfg; dev = v.dev; serial = v.serial; jack = v.jack;
    adc0 = v.a0; adc1 = v.a1; adc2 = v.a2; adc3 = v.a3;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkFrame(input string name, input frame_t f, input string exp);
    compared++;
    if (f.text != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, esc(f.text), esc(exp));
    end
    checkOutput({name, " byte spacing/stop errors"}, f.gaps, 0);
  endtask

  task automatic pop_frame(input int inst, input string name, output frame_t f, output bit ok);
    int n = 0;
    f.text = ""; f.start = 0; f.gaps = 0;
    while (n < 6000 &&
           ((inst == 0 && q_main.size() == 0) || (inst == 1 && q_w12.size() == 0) ||
            (inst == 2 && q_div2.size() == 0))) begin
      @(negedge clk);
      n++;
    end
    ok = 1;
    case (inst)
      0:       if (q_main.size() > 0) f = q_main.pop_front(); else ok = 0;
      1:       if (q_w12.size() > 0)  f = q_w12.pop_front();  else ok = 0;
      default: if (q_div2.size() > 0) f = q_div2.pop_front(); else ok = 0;
    endcase
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no frame within 6000 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    frame_t f;
    bit ok;
    int rel_cyc, run, prev_start, target;
    vec_t v;

    crlf = "\015\012";
    vecs[0] = '{8'h12, 8'h34, 32'hDEADBEEF, 8'h0F, 16'h1234, 16'hFFFF, 16'h8000, 16'h0000,
                "1234DEADBEEF 0F 1234 FFFF 8000 0000"};
    vecs[1] = '{8'hAB, 8'hCD, 32'h01234567, 8'h80, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h00A5,
                "ABCD01234567 80 7FFF 0001 FFFE 00A5"};
    vecs[2] = '{8'hFF, 8'h00, 32'h89ABCDEF, 8'hFF, 16'h8001, 16'h1000, 16'h0F0F, 16'hC3C3,
                "FF0089ABCDEF FF 8001 1000 0F0F C3C3"};

    applyStimulus(vecs[0]);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("tx_main idle in reset", int'(tx_main), 1);
    checkOutput("tx_w12 idle in reset", int'(tx_w12), 1);
    checkOutput("tx_div2 idle in reset", int'(tx_div2), 1);
    rst = 1'b0;
    @(negedge clk);
    rel_cyc = cyc;
    checkOutput("start bit right after reset", int'(tx_main), 0);
    run = 0;
    while (tx_main === 1'b0 && run < 100) begin
      run++;
      @(negedge clk);
    end
    checkOutput("first start bit length", run, 12);

    // Table vectors: each is applied between frames so the next frame snapshots it.
    prev_start = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) applyStimulus(vecs[i]);
      pop_frame(0, $sformatf("vec%0d frame", i), f, ok);
      if (ok) begin
        checkFrame($sformatf("vec%0d frame", i), f, {vecs[i].text, crlf});
        checkOutput($sformatf("vec%0d frame length", i), f.text.len(), 37);
        if (i == 0) checkOutput("first frame start cycle", f.start, rel_cyc);
        else        checkOutput($sformatf("vec%0d frame period", i), f.start - prev_start, 4440);
        prev_start = f.start;
      end
    end

    // adc0 changes mid-frame: only the following frame may see it.
    v = vecs[0];
    v.a0 = 16'h0001;
    applyStimulus(v);
    repeat (1500) @(negedge clk);
    adc0 = 16'h7FFF;
    pop_frame(0, "snapshot frame", f, ok);
    if (ok) begin
      checkFrame("snapshot frame", f, {"1234DEADBEEF 0F 0001 FFFF 8000 0000", crlf});
      checkOutput("snapshot frame period", f.start - prev_start, 4440);
      prev_start = f.start;
    end
    pop_frame(0, "updated frame", f, ok);
    if (ok) begin
      checkFrame("updated frame", f, {"1234DEADBEEF 0F 7FFF FFFF 8000 0000", crlf});
      checkOutput("updated frame period", f.start - prev_start, 4440);
      prev_start = f.start;
    end

    // Reset for 3 cycles in the middle of byte 10 of the next frame.
    target = prev_start + 4440 + 10 * 120 + 50;
    while (cyc < target) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("tx high during mid-frame reset cycle %0d", c), int'(tx_main), 1);
    end
    rst = 1'b0;
    @(negedge clk);
    rel_cyc = cyc;
    checkOutput("start bit after mid-frame reset", int'(tx_main), 0);
    pop_frame(0, "post-reset frame", f, ok);
    if (ok) begin
      checkFrame("post-reset frame", f, {"1234DEADBEEF 0F 7FFF FFFF 8000 0000", crlf});
      checkOutput("post-reset frame start cycle", f.start, rel_cyc);
    end

    // W=12 instance: 3-digit fields, 33-byte frames, DIV=4.
    pop_frame(1, "w12 frame", f, ok);
    if (ok) begin
      checkFrame("w12 frame", f, {"ABC012345678 5A FFF 800 07F 000", crlf});
      checkOutput("w12 frame length", f.text.len(), 33);
      prev_start = f.start;
      pop_frame(1, "w12 second frame", f, ok);
      if (ok) checkOutput("w12 frame period", f.start - prev_start, 10 * 4 * 33);
    end

    // DIV=2 instance with all-zero inputs.
    pop_frame(2, "div2 frame", f, ok);
    if (ok) begin
      checkFrame("div2 frame", f, {"000000000000 00 0000 0000 0000 0000", crlf});
      prev_start = f.start;
      pop_frame(2, "div2 second frame", f, ok);
      if (ok) checkOutput("div2 frame period", f.start - prev_start, 10 * 2 * 37);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
